// File: rtl/cache_mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and physical-memory ports seen by cache_mem_arbiter.
// The slave modport is the arbiter's view; master is the clients-plus-memory side.
interface cache_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 256
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic              i_resp;
  logic [LINE_W-1:0] i_rdata;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic              d_resp;
  logic [LINE_W-1:0] d_rdata;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic              pmem_resp;
  logic [LINE_W-1:0] pmem_rdata;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_resp, pmem_rdata,
    output i_resp, i_rdata, d_resp, d_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_resp, pmem_rdata,
    input  i_resp, i_rdata, d_resp, d_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter merging I-cache and D-cache line traffic onto one memory port.
// The granted request is latched and held on the memory port until pmem_resp.
module cache_mem_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 256
) (
  input  logic               clk,
  input  logic               rst,
  cache_mem_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;
  localparam logic [1:0] TURN    = 2'd3;

  logic [1:0]        state;
  logic              last_d;
  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [LINE_W-1:0] lat_wdata;
  logic              pend_i;
  logic              pend_d;
  logic              grant_d;
  logic              serving;

  // D wins when it is alone, or on a tie when I was served last.
  always_comb begin
    pend_i  = bus.i_read;
    pend_d  = bus.d_read | bus.d_write;
    grant_d = pend_d & (~pend_i | ~last_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_d    <= 1'b0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= SERVE_D;
            lat_write <= bus.d_write;
            lat_addr  <= bus.d_address;
            lat_wdata <= bus.d_wdata;
          end else if (pend_i) begin
            state     <= SERVE_I;
            lat_write <= 1'b0;
            lat_addr  <= bus.i_address;
          end
        end
        SERVE_I: begin
          if (bus.pmem_resp) begin
            state  <= TURN;
            last_d <= 1'b0;
          end
        end
        SERVE_D: begin
          if (bus.pmem_resp) begin
            state  <= TURN;
            last_d <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign serving = (state == SERVE_I) || (state == SERVE_D);

  assign bus.pmem_read    = serving & ~lat_write;
  assign bus.pmem_write   = serving &  lat_write;
  assign bus.pmem_address = lat_addr;
  assign bus.pmem_wdata   = lat_wdata;

  assign bus.i_resp  = bus.pmem_resp & (state == SERVE_I);
  assign bus.d_resp  = bus.pmem_resp & (state == SERVE_D);
  assign bus.i_rdata = bus.pmem_rdata;
  assign bus.d_rdata = bus.pmem_rdata;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: expected memory transactions are queued
// as requests are driven and checked as the arbiter presents them to memory.
module tb_cache_mem_arbiter;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned LINE_W = 256;

  typedef struct {
    bit                d;
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    bit                drop;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();
  cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  txn_t        sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check_val(input string tag, input logic [LINE_W-1:0] got,
                           input logic [LINE_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic push(input bit d, input bit wr, input logic [ADDR_W-1:0] addr,
                      input logic [LINE_W-1:0] wdata, input bit drop);
    txn_t e;
    e.d = d; e.wr = wr; e.addr = addr; e.wdata = wdata; e.drop = drop;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Wait for a strobe, compare against the scoreboard head, hold for lat cycles,
  // then answer and check routing and the TURN cycle that follows.
  task automatic serve_one(input int unsigned lat, input logic [LINE_W-1:0] rd,
                           input bit mut, output int unsigned waited);
    txn_t e;
    waited = 0;
    while (!(bus.pmem_read || bus.pmem_write) && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!(bus.pmem_read || bus.pmem_write)) begin
      check_val("strobe_timeout", LINE_W'(bus.pmem_read | bus.pmem_write), LINE_W'(1'b1));
      return;
    end
    if (sb.size() == 0) begin
      check_val("sb_nonempty", LINE_W'(sb.size() != 0), LINE_W'(1'b1));
      return;
    end
    e = sb.pop_front();
    check_val("pmem_read",  LINE_W'(bus.pmem_read),  LINE_W'(!e.wr));
    check_val("pmem_write", LINE_W'(bus.pmem_write), LINE_W'(e.wr));
    check_val("pmem_addr",  LINE_W'(bus.pmem_address), LINE_W'(e.addr));
    if (e.wr) check_val("pmem_wdata", bus.pmem_wdata, e.wdata);
    if (mut) begin
      bus.d_address = 16'h4000;
      bus.d_wdata   = ~bus.d_wdata;
    end
    for (int unsigned k = 0; k < lat; k++) begin
      @(posedge clk); #1;
      check_val("hold_addr",   LINE_W'(bus.pmem_address), LINE_W'(e.addr));
      check_val("hold_strobe", LINE_W'({bus.pmem_read, bus.pmem_write}), LINE_W'({!e.wr, e.wr}));
      check_val("hold_noresp", LINE_W'({bus.i_resp, bus.d_resp}), LINE_W'(2'b00));
    end
    bus.pmem_rdata = rd;
    bus.pmem_resp  = 1'b1;
    #1;
    check_val("i_resp", LINE_W'(bus.i_resp), LINE_W'(!e.d));
    check_val("d_resp", LINE_W'(bus.d_resp), LINE_W'(e.d));
    check_val("rdata", e.d ? bus.d_rdata : bus.i_rdata, rd);
    @(posedge clk); #1;
    check_val("turn_strobe", LINE_W'({bus.pmem_read, bus.pmem_write}), LINE_W'(2'b00));
    check_val("turn_resp",   LINE_W'({bus.i_resp, bus.d_resp}), LINE_W'(2'b00));
    bus.pmem_resp = 1'b0;
    if (e.drop) begin
      if (e.d) begin
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
      end else begin
        bus.i_read = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned w;
    logic [LINE_W-1:0] wd;
    bus.i_read = 1'b0; bus.i_address = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;
    bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;
    do_reset();

    check_val("rst_strobe", LINE_W'({bus.pmem_read, bus.pmem_write}), LINE_W'(2'b00));
    check_val("rst_addr",   LINE_W'(bus.pmem_address), LINE_W'(16'h0));
    check_val("rst_wdata",  bus.pmem_wdata, '0);
    check_val("rst_resp",   LINE_W'({bus.i_resp, bus.d_resp}), LINE_W'(2'b00));

    // I-only read
    bus.i_address = 16'h1240; bus.i_read = 1'b1;
    push(1'b0, 1'b0, 16'h1240, '0, 1'b1);
    serve_one(2, {32{8'hA5}}, 1'b0, w);
    check_val("first_latency", LINE_W'(w), LINE_W'(1));

    // D write, then D read+write treated as write
    wd = '0; wd[31:0] = 32'hDEAD_BEEF;
    bus.d_address = 16'h2000; bus.d_wdata = wd; bus.d_write = 1'b1;
    push(1'b1, 1'b1, 16'h2000, wd, 1'b1);
    serve_one(1, rand_line(), 1'b0, w);
    check_val("d_latency", LINE_W'(w), LINE_W'(2));
    wd = rand_line();
    bus.d_address = 16'h2040; bus.d_wdata = wd; bus.d_read = 1'b1; bus.d_write = 1'b1;
    push(1'b1, 1'b1, 16'h2040, wd, 1'b1);
    serve_one(0, rand_line(), 1'b0, w);

    // Ties right after reset: D, then I, then D again
    do_reset();
    bus.i_address = 16'h1000; bus.d_address = 16'h1800;
    bus.i_read = 1'b1; bus.d_read = 1'b1;
    push(1'b1, 1'b0, 16'h1800, '0, 1'b1);
    push(1'b0, 1'b0, 16'h1000, '0, 1'b1);
    serve_one(1, rand_line(), 1'b0, w);
    check_val("tie_first_latency", LINE_W'(w), LINE_W'(1));
    serve_one(2, rand_line(), 1'b0, w);
    check_val("tie_gap", LINE_W'(w), LINE_W'(2));
    bus.i_address = 16'h1100; bus.d_address = 16'h1900;
    bus.i_read = 1'b1; bus.d_read = 1'b1;
    push(1'b1, 1'b0, 16'h1900, '0, 1'b1);
    push(1'b0, 1'b0, 16'h1100, '0, 1'b1);
    serve_one(0, rand_line(), 1'b0, w);
    serve_one(1, rand_line(), 1'b0, w);

    // Both held: strict alternation
    bus.i_address = 16'h0A00; bus.d_address = 16'h0B00;
    bus.i_read = 1'b1; bus.d_read = 1'b1;
    for (int n = 0; n < 3; n++) begin
      push(1'b1, 1'b0, 16'h0B00, '0, n == 2);
      push(1'b0, 1'b0, 16'h0A00, '0, n == 2);
    end
    for (int n = 0; n < 6; n++) serve_one($urandom_range(0, 3), rand_line(), 1'b0, w);

    // Client changes address mid-transaction
    bus.d_address = 16'h3000; bus.d_read = 1'b1;
    push(1'b1, 1'b0, 16'h3000, '0, 1'b1);
    serve_one(3, rand_line(), 1'b1, w);

    // Reset during SERVE_D abandons the transaction
    bus.d_address = 16'h5000; bus.d_wdata = rand_line(); bus.d_write = 1'b1;
    w = 0;
    while (!bus.pmem_write && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check_val("pre_rst_write", LINE_W'(bus.pmem_write), LINE_W'(1'b1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.d_write = 1'b0;
    check_val("midrst_strobe", LINE_W'({bus.pmem_read, bus.pmem_write}), LINE_W'(2'b00));
    bus.pmem_rdata = rand_line(); bus.pmem_resp = 1'b1;
    #1;
    check_val("late_resp", LINE_W'({bus.i_resp, bus.d_resp}), LINE_W'(2'b00));
    @(posedge clk); #1;
    bus.pmem_resp = 1'b0;
    check_val("late_resp_strobe", LINE_W'({bus.pmem_read, bus.pmem_write}), LINE_W'(2'b00));
    bus.i_address = 16'h6000; bus.i_read = 1'b1;
    push(1'b0, 1'b0, 16'h6000, '0, 1'b1);
    serve_one(1, rand_line(), 1'b0, w);
    check_val("post_rst_latency", LINE_W'(w), LINE_W'(1));
    check_val("sb_drained", LINE_W'(sb.size()), LINE_W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
